// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns one register-level request (device, register, N bytes,
// read or write) into the cmd/dat/ws step sequence driven into i2c_master,
// streaming write bytes in and read bytes out, and aborting cleanly with
// CLRS + STOP when the master reports an error.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | req_ready high, waiting for a request
// ISSUE     | drive m_cmd/m_dat and pulse m_ws (write data waits on wr_valid)
// WAIT_ACC  | wait for the master to go busy or flag an error
// WAIT_DONE | wait for the master to drop busy
// CHECK     | inspect status, deliver read byte, advance to the next step
// CLR       | pulse C_CLRS, then wait for the error flag to drop
// ABORT     | pulse C_STOP, wait for it to complete, ignoring errors
// FIN       | done strobe (err qualifies it), then back to IDLE

module i2c_reg_seq #(
   parameter int LEN_W = 4,
   parameter int C_SZ  = 6,
   parameter int S_SZ  = 2
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_rd,
   input  logic [6:0]           req_dev,
   input  logic [7:0]           req_reg,
   input  logic [LEN_W-1:0]     req_len,
   input  logic [7:0]           wr_data,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   output logic [7:0]           rd_data,
   output logic                 rd_valid,
   output logic                 done,
   output logic                 err,
   output logic [LEN_W+1:0]     err_step,
   output logic [C_SZ-1:0]      m_cmd,
   output logic [7:0]           m_dat,
   output logic                 m_ws,
   input  logic [S_SZ-1:0]      m_stat,
   input  logic [7:0]           m_dat_in
);

   localparam int STEP_W = LEN_W + 2;

   // Master command bits (one-hot flags, OR-able)
   localparam logic [C_SZ-1:0] C_STRT = C_SZ'(1);
   localparam logic [C_SZ-1:0] C_STOP = C_SZ'(2);
   localparam logic [C_SZ-1:0] C_READ = C_SZ'(4);
   localparam logic [C_SZ-1:0] C_WRTE = C_SZ'(8);
   localparam logic [C_SZ-1:0] C_NACK = C_SZ'(16);
   localparam logic [C_SZ-1:0] C_CLRS = C_SZ'(32);

   // Master status bit positions
   localparam int SB_BSY = 0;
   localparam int SB_ERR = 1;

   typedef enum logic [2:0] {
      ST_IDLE, ST_ISSUE, ST_WAIT_ACC, ST_WAIT_DONE,
      ST_CHECK, ST_CLR, ST_ABORT, ST_FIN
   } state_t;

   state_t              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic                rd_q, rd_d;
   logic [6:0]          dev_q, dev_d;
   logic [7:0]          reg_q, reg_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [1:0]          phase_q, phase_d;
   logic                req_ready_q, req_ready_d;
   logic                wr_ready_q, wr_ready_d;
   logic [7:0]          rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [STEP_W-1:0]   err_step_q, err_step_d;
   logic [C_SZ-1:0]     m_cmd_q, m_cmd_d;
   logic [7:0]          m_dat_q, m_dat_d;
   logic                m_ws_q, m_ws_d;

   logic [STEP_W-1:0]   last_step;
   logic                is_wr_data;
   logic                is_rd_data;
   logic                is_last;
   logic [C_SZ-1:0]     step_cmd;
   logic [7:0]          step_dat;
   logic                st_bsy;
   logic                st_err;

   assign st_bsy = m_stat[SB_BSY];
   assign st_err = m_stat[SB_ERR];

   // Decode the command/data for the current step from the latched request
   always_comb begin
      last_step  = STEP_W'(len_q) + (rd_q ? STEP_W'(3) : STEP_W'(2));
      is_wr_data = !rd_q && (step_q >= STEP_W'(2));
      is_rd_data = rd_q && (step_q >= STEP_W'(3));
      is_last    = (step_q == last_step);
      step_cmd   = C_WRTE;
      step_dat   = 8'h00;
      if (step_q == STEP_W'(0)) begin
         step_cmd = C_STRT | C_WRTE;
         step_dat = {dev_q, 1'b0};
      end else if (step_q == STEP_W'(1)) begin
         step_cmd = C_WRTE;
         step_dat = reg_q;
      end else if (rd_q && step_q == STEP_W'(2)) begin
         step_cmd = C_STRT | C_WRTE;
         step_dat = {dev_q, 1'b1};
      end else if (rd_q) begin
         step_cmd = is_last ? (C_READ | C_NACK | C_STOP) : C_READ;
      end else begin
         step_cmd = is_last ? (C_WRTE | C_STOP) : C_WRTE;
         step_dat = wr_data;
      end
   end

   // Next-state and next-output logic; strobes default low every cycle
   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      rd_d       = rd_q;
      dev_d      = dev_q;
      reg_d      = reg_q;
      len_d      = len_q;
      phase_d    = phase_q;
      rd_data_d  = rd_data_q;
      err_step_d = err_step_q;
      m_cmd_d    = m_cmd_q;
      m_dat_d    = m_dat_q;
      wr_ready_d = 1'b0;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      m_ws_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               rd_d    = req_rd;
               dev_d   = req_dev;
               reg_d   = req_reg;
               len_d   = req_len;
               step_d  = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!is_wr_data || wr_valid) begin
               m_cmd_d    = step_cmd;
               m_dat_d    = step_dat;
               m_ws_d     = 1'b1;
               wr_ready_d = is_wr_data;
               state_d    = ST_WAIT_ACC;
            end
         end
         ST_WAIT_ACC: begin
            if (st_err) begin
               err_step_d = step_q;
               phase_d    = 2'd0;
               state_d    = ST_CLR;
            end else if (st_bsy) begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (!st_bsy) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (st_err) begin
               err_step_d = step_q;
               phase_d    = 2'd0;
               state_d    = ST_CLR;
            end else begin
               if (is_rd_data) begin
                  rd_data_d  = m_dat_in;
                  rd_valid_d = 1'b1;
               end
               if (is_last) begin
                  done_d  = 1'b1;
                  state_d = ST_FIN;
               end else begin
                  step_d  = step_q + STEP_W'(1);
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_CLR: begin
            if (phase_q == 2'd0) begin
               m_cmd_d = C_CLRS;
               m_ws_d  = 1'b1;
               phase_d = 2'd1;
            end else if (!st_err) begin
               phase_d = 2'd0;
               state_d = ST_ABORT;
            end
         end
         ST_ABORT: begin
            // Errors raised by the STOP itself are deliberately not acted on
            if (phase_q == 2'd0) begin
               m_cmd_d = C_STOP;
               m_ws_d  = 1'b1;
               phase_d = 2'd1;
            end else if (phase_q == 2'd1) begin
               if (st_bsy || st_err) phase_d = 2'd2;
            end else if (!st_bsy) begin
               phase_d = 2'd0;
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= ST_IDLE;
         step_q      <= '0;
         rd_q        <= 1'b0;
         dev_q       <= '0;
         reg_q       <= '0;
         len_q       <= '0;
         phase_q     <= '0;
         req_ready_q <= 1'b1;
         wr_ready_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_step_q  <= '0;
         m_cmd_q     <= '0;
         m_dat_q     <= '0;
         m_ws_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         rd_q        <= rd_d;
         dev_q       <= dev_d;
         reg_q       <= reg_d;
         len_q       <= len_d;
         phase_q     <= phase_d;
         req_ready_q <= req_ready_d;
         wr_ready_q  <= wr_ready_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_step_q  <= err_step_d;
         m_cmd_q     <= m_cmd_d;
         m_dat_q     <= m_dat_d;
         m_ws_q      <= m_ws_d;
      end
   end

   assign req_ready = req_ready_q;
   assign wr_ready  = wr_ready_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_step  = err_step_q;
   assign m_cmd     = m_cmd_q;
   assign m_dat     = m_dat_q;
   assign m_ws      = m_ws_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: a behavioural i2c_master + RAM slave answers the
// command strobes; expected command lists and read data come from the
// request parameters and a reference memory kept by the bench.

module tb_i2c_reg_seq;
   localparam int LEN_W = 4;
   localparam logic [6:0] SLV = 7'h3a;
   localparam logic [7:0] RO_REG = 8'hee;
   localparam logic [5:0] C_STRT = 6'd1, C_STOP = 6'd2, C_READ = 6'd4,
                          C_WRTE = 6'd8, C_NACK = 6'd16, C_CLRS = 6'd32;

   logic clk = 1'b0, aresetn = 1'b0;
   logic req_valid = 1'b0, req_ready, req_rd = 1'b0;
   logic [6:0] req_dev = '0;
   logic [7:0] req_reg = '0;
   logic [LEN_W-1:0] req_len = '0;
   logic [7:0] wr_data = '0;
   logic wr_valid = 1'b0, wr_ready;
   logic [7:0] rd_data;
   logic rd_valid, done, err;
   logic [LEN_W+1:0] err_step;
   logic [5:0] m_cmd;
   logic [7:0] m_dat;
   logic m_ws;
   logic [1:0] m_stat;
   logic [7:0] m_dat_in;

   always #5 clk = ~clk;

   i2c_reg_seq #(.LEN_W(LEN_W), .C_SZ(6), .S_SZ(2)) dut (
      .clk(clk), .aresetn(aresetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
      .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
      .err_step(err_step), .m_cmd(m_cmd), .m_dat(m_dat), .m_ws(m_ws),
      .m_stat(m_stat), .m_dat_in(m_dat_in)
   );

   // ---------------- master + RAM slave model ----------------
   logic mst_busy, mst_err, bus_idle, clr_pend, slv_sel, slv_need_ptr;
   logic fast_err = 1'b0;
   int   mst_cnt;
   logic [5:0] op_cmd;
   logic [7:0] op_dat, slv_ptr, mst_dout;
   logic [7:0] slv_mem [256];
   assign m_stat   = {mst_err, mst_busy};
   assign m_dat_in = mst_dout;

   always @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         mst_busy <= 0; mst_err <= 0; bus_idle <= 1; clr_pend <= 0;
         slv_sel <= 0; slv_need_ptr <= 0; mst_cnt <= 0; mst_dout <= 0;
         op_cmd <= 0; op_dat <= 0; slv_ptr <= 0;
      end else begin
         if (clr_pend) begin mst_err <= 0; clr_pend <= 0; end
         if (m_ws) begin
            if ((m_cmd & C_CLRS) != 0) clr_pend <= 1;
            else if ((m_cmd & C_STRT) != 0 && m_dat[7:1] != SLV && fast_err) begin
               mst_err <= 1; bus_idle <= 0;
            end else begin
               mst_busy <= 1; mst_cnt <= $urandom_range(0, 4);
               op_cmd <= m_cmd; op_dat <= m_dat;
            end
         end else if (mst_busy) begin
            if (mst_cnt > 0) mst_cnt <= mst_cnt - 1;
            else begin
               mst_busy <= 0;
               if ((op_cmd & C_STRT) != 0) begin
                  bus_idle <= 0;
                  if (op_dat[7:1] == SLV) begin
                     slv_sel <= 1; slv_need_ptr <= !op_dat[0];
                  end else begin
                     slv_sel <= 0; mst_err <= 1;
                  end
               end else if ((op_cmd & C_WRTE) != 0 && slv_sel) begin
                  if (slv_need_ptr) begin slv_ptr <= op_dat; slv_need_ptr <= 0; end
                  else if (slv_ptr == RO_REG) mst_err <= 1;
                  else begin slv_mem[slv_ptr] <= op_dat; slv_ptr <= slv_ptr + 1; end
               end else if ((op_cmd & C_READ) != 0 && slv_sel) begin
                  mst_dout <= slv_mem[slv_ptr]; slv_ptr <= slv_ptr + 1;
               end
               if ((op_cmd & C_STOP) != 0) begin bus_idle <= 1; slv_sel <= 0; end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   logic [5:0] obs_cmd[$];
   logic [7:0] obs_dat[$], obs_rd[$];
   int wr_pulses = 0, ws_space_bad = 0, cyc = 0, last_ws = -10;
   int ws_stall_start = 0, ws_stall_end = 0;
   always @(negedge clk) begin
      cyc++;
      if (aresetn) begin
         if (m_ws) begin
            if (cyc - last_ws < 2) ws_space_bad++;
            last_ws = cyc;
            obs_cmd.push_back(m_cmd); obs_dat.push_back(m_dat);
         end
         if (rd_valid) obs_rd.push_back(rd_data);
         if (wr_ready) wr_pulses++;
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] ref_mem [256];
   logic [7:0] wr_bytes [17];
   logic [5:0] exp_cmd[$];
   logic [7:0] exp_dat[$];
   logic       exp_chk[$];
   int n_cmp = 0, n_bad = 0;

   task automatic build_exp(input logic rd, input logic [6:0] dev, input logic [7:0] rg, input int len);
      exp_cmd.delete(); exp_dat.delete(); exp_chk.delete();
      exp_cmd.push_back(C_STRT | C_WRTE); exp_dat.push_back({dev, 1'b0}); exp_chk.push_back(1);
      exp_cmd.push_back(C_WRTE);          exp_dat.push_back(rg);          exp_chk.push_back(1);
      if (rd) begin
         exp_cmd.push_back(C_STRT | C_WRTE); exp_dat.push_back({dev, 1'b1}); exp_chk.push_back(1);
         for (int i = 0; i <= len; i++) begin
            exp_cmd.push_back(i == len ? (C_READ | C_NACK | C_STOP) : C_READ);
            exp_dat.push_back(8'h00); exp_chk.push_back(0);
         end
      end else begin
         for (int i = 0; i <= len; i++) begin
            exp_cmd.push_back(i == len ? (C_WRTE | C_STOP) : C_WRTE);
            exp_dat.push_back(wr_bytes[i]); exp_chk.push_back(1);
         end
      end
   endtask

   function automatic int cmd_diff();
      if (obs_cmd.size() != exp_cmd.size()) return -2;
      for (int i = 0; i < exp_cmd.size(); i++)
         if (obs_cmd[i] !== exp_cmd[i] || (exp_chk[i] && obs_dat[i] !== exp_dat[i])) return i;
      return -1;
   endfunction

   function automatic int rd_diff(input logic [7:0] rg, input int len);
      logic [7:0] a;
      if (obs_rd.size() != len + 1) return -2;
      for (int i = 0; i <= len; i++) begin
         a = rg + 8'(i);
         if (obs_rd[i] !== ref_mem[a]) return i;
      end
      return -1;
   endfunction

   task automatic commit_write(input logic [7:0] rg, input int len);
      logic [7:0] a;
      for (int i = 0; i <= len; i++) begin a = rg + 8'(i); ref_mem[a] = wr_bytes[i]; end
   endtask

   // Host side: offers the request, streams wr_bytes, waits (bounded) for done
   task automatic run_txn(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                          input int len, input int st_idx, input int st_len,
                          output logic g_err, output logic [5:0] g_step);
      int wr_idx, st_cnt;
      logic got;
      obs_cmd.delete(); obs_dat.delete(); obs_rd.delete();
      wr_pulses = 0; ws_space_bad = 0;
      @(negedge clk);
      req_rd = rd; req_dev = dev; req_reg = rg; req_len = LEN_W'(len);
      req_valid = 1; wr_valid = 0;
      wr_idx = 0; st_cnt = 0; got = 0; g_err = 0; g_step = 0;
      for (int c = 0; c < 3000 && !got; c++) begin
         @(negedge clk);
         if (!req_ready) req_valid = 0;
         if (done) begin got = 1; g_err = err; g_step = err_step; end
         if (wr_ready) wr_idx++;
         if (!rd && st_len > 0 && wr_idx == st_idx && st_cnt < st_len) begin
            st_cnt++;
            wr_valid = 0;
            if (st_cnt == 2) ws_stall_start = obs_cmd.size();
            if (st_cnt == st_len) ws_stall_end = obs_cmd.size();
         end else begin
            wr_valid = !rd && (wr_idx <= len);
            wr_data  = wr_bytes[wr_idx > 16 ? 16 : wr_idx];
         end
      end
      req_valid = 0; wr_valid = 0;
      #1;
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL txn_done: done seen=0 want 1"); end
   endtask

   // ---------------- tests ----------------
   logic g_err;
   logic [5:0] g_step;
   int d;

   task automatic test_reset();
      logic [33:0] v;
      aresetn = 0;
      #13;
      v = {req_ready, wr_ready, rd_valid, done, err, m_ws, m_cmd, m_dat, err_step, rd_data};
      n_cmp++;
      if (v !== {1'b1, 33'b0}) begin n_bad++; $display("FAIL reset_vals: got %h want %h", v, {1'b1, 33'b0}); end
      @(negedge clk); aresetn = 1;
   endtask

   task automatic test_write();
      wr_bytes[0] = 8'h11; wr_bytes[1] = 8'h22; wr_bytes[2] = 8'h33; wr_bytes[3] = 8'h44;
      run_txn(0, SLV, 8'h00, 3, 0, 0, g_err, g_step);
      build_exp(0, SLV, 8'h00, 3);
      d = cmd_diff();
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL wr_cmds: diff idx %0d want -1", d); end
      n_cmp++; if (g_err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b want 0", g_err); end
      n_cmp++; if (wr_pulses != 4) begin n_bad++; $display("FAIL wr_pulses: got %0d want 4", wr_pulses); end
      n_cmp++; if (ws_space_bad != 0) begin n_bad++; $display("FAIL ws_spacing: got %0d want 0", ws_space_bad); end
      commit_write(8'h00, 3);
   endtask

   task automatic test_read();
      run_txn(1, SLV, 8'h00, 3, 0, 0, g_err, g_step);
      build_exp(1, SLV, 8'h00, 3);
      d = cmd_diff();
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL rd_cmds: diff idx %0d want -1", d); end
      d = rd_diff(8'h00, 3);
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL rd_data: diff idx %0d want -1", d); end
      n_cmp++; if (g_err !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b want 0", g_err); end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 4; i++) wr_bytes[i] = 8'($urandom);
      run_txn(0, SLV, 8'h40, 3, 2, 50, g_err, g_step);
      build_exp(0, SLV, 8'h40, 3);
      d = cmd_diff();
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL bp_cmds: diff idx %0d want -1", d); end
      n_cmp++; if (ws_stall_end != ws_stall_start) begin n_bad++;
         $display("FAIL bp_stall_ws: got %0d strobes want 0", ws_stall_end - ws_stall_start); end
      commit_write(8'h40, 3);
      run_txn(1, SLV, 8'h40, 3, 0, 0, g_err, g_step);
      d = rd_diff(8'h40, 3);
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL bp_readback: diff idx %0d want -1", d); end
   endtask

   task automatic test_max_len();
      for (int i = 0; i < 16; i++) wr_bytes[i] = 8'(i);
      run_txn(0, SLV, 8'h80, 15, 0, 0, g_err, g_step);
      build_exp(0, SLV, 8'h80, 15);
      d = cmd_diff();
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL max_wr_cmds: diff idx %0d want -1", d); end
      commit_write(8'h80, 15);
      run_txn(1, SLV, 8'h80, 15, 0, 0, g_err, g_step);
      build_exp(1, SLV, 8'h80, 15);
      d = cmd_diff();
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL max_rd_cmds: diff idx %0d want -1", d); end
      d = rd_diff(8'h80, 15);
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL max_rd_data: diff idx %0d want -1", d); end
      n_cmp++; if (g_err !== 1'b0 || err_step !== 6'd0) begin n_bad++;
         $display("FAIL max_err_step: got err=%b step=%0d want 0/0", g_err, err_step); end
   endtask

   task automatic test_absent(input logic fast);
      fast_err = fast;
      wr_bytes[0] = 8'h5a;
      run_txn(0, 7'h10, 8'h00, 0, 0, 0, g_err, g_step);
      n_cmp++; if (g_err !== 1'b1 || g_step !== 6'd0) begin n_bad++;
         $display("FAIL absent_err: got err=%b step=%0d want 1/0 (fast=%b)", g_err, g_step, fast); end
      n_cmp++;
      if (obs_cmd.size() != 3 || obs_cmd[0] !== (C_STRT | C_WRTE) || obs_dat[0] !== 8'h20 ||
          obs_cmd[1] !== C_CLRS || obs_cmd[2] !== C_STOP) begin
         n_bad++;
         $display("FAIL absent_cmds: got n=%0d first=%h want n=3 STRT|WRTE,CLRS,STOP (fast=%b)",
                  obs_cmd.size(), obs_size_first(), fast);
      end
      n_cmp++; if (wr_pulses != 0) begin n_bad++; $display("FAIL absent_wr: got %0d want 0", wr_pulses); end
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1 || bus_idle !== 1'b1) begin n_bad++;
         $display("FAIL absent_idle: got rdy=%b bus_idle=%b want 1/1", req_ready, bus_idle); end
      fast_err = 0;
   endtask

   function automatic logic [5:0] obs_size_first();
      return (obs_cmd.size() > 0) ? obs_cmd[0] : 6'h3f;
   endfunction

   task automatic test_data_nack();
      wr_bytes[0] = 8'ha1; wr_bytes[1] = 8'ha2; wr_bytes[2] = 8'ha3; wr_bytes[3] = 8'ha4;
      run_txn(0, SLV, 8'hec, 3, 0, 0, g_err, g_step);
      n_cmp++; if (g_err !== 1'b1 || g_step !== 6'd4) begin n_bad++;
         $display("FAIL nack_step: got err=%b step=%0d want 1/4", g_err, g_step); end
      n_cmp++; if (wr_pulses != 3) begin n_bad++; $display("FAIL nack_wr: got %0d want 3", wr_pulses); end
      n_cmp++; if (obs_cmd.size() != 7 || obs_cmd[5] !== C_CLRS || obs_cmd[6] !== C_STOP) begin n_bad++;
         $display("FAIL nack_cmds: got n=%0d want 7 ending CLRS,STOP", obs_cmd.size()); end
      @(negedge clk);
      n_cmp++; if (bus_idle !== 1'b1) begin n_bad++; $display("FAIL nack_idle: got %b want 1", bus_idle); end
   endtask

   task automatic test_random();
      int len, rlen, st_idx, st_len;
      logic [7:0] rg;
      for (int k = 0; k < 6; k++) begin
         len = $urandom_range(0, 15); rg = 8'($urandom_range(0, 8'hb0));
         st_idx = $urandom_range(0, len); st_len = $urandom_range(0, 12);
         for (int i = 0; i <= len; i++) wr_bytes[i] = 8'($urandom);
         run_txn(0, SLV, rg, len, st_idx, st_len, g_err, g_step);
         build_exp(0, SLV, rg, len);
         d = cmd_diff();
         n_cmp++; if (d != -1 || g_err !== 1'b0) begin n_bad++;
            $display("FAIL rand_wr[%0d]: diff idx %0d err=%b want -1/0", k, d, g_err); end
         commit_write(rg, len);
         rlen = $urandom_range(0, len);
         run_txn(1, SLV, rg, rlen, 0, 0, g_err, g_step);
         d = rd_diff(rg, rlen);
         n_cmp++; if (d != -1) begin n_bad++; $display("FAIL rand_rd[%0d]: diff idx %0d want -1", k, d); end
      end
   endtask

   task automatic test_reset_mid();
      logic [33:0] v;
      logic hit;
      obs_cmd.delete(); obs_dat.delete(); obs_rd.delete();
      @(negedge clk);
      req_rd = 1; req_dev = SLV; req_reg = 8'h00; req_len = 4'd3; req_valid = 1;
      hit = 0;
      for (int c = 0; c < 500 && !hit; c++) begin
         @(negedge clk);
         if (!req_ready) req_valid = 0;
         if (obs_cmd.size() >= 4) hit = 1;
      end
      req_valid = 0;
      n_cmp++; if (!hit) begin n_bad++; $display("FAIL mid_reach_s3: reached=0 want 1"); end
      #2 aresetn = 0;
      #1;
      v = {req_ready, wr_ready, rd_valid, done, err, m_ws, m_cmd, m_dat, err_step, rd_data};
      n_cmp++;
      if (v !== {1'b1, 33'b0}) begin n_bad++; $display("FAIL mid_reset_vals: got %h want %h", v, {1'b1, 33'b0}); end
      @(negedge clk); aresetn = 1;
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", req_ready); end
      wr_bytes[0] = 8'h77; wr_bytes[1] = 8'h88;
      run_txn(0, SLV, 8'h20, 1, 0, 0, g_err, g_step);
      build_exp(0, SLV, 8'h20, 1);
      d = cmd_diff();
      n_cmp++; if (d != -1 || g_err !== 1'b0) begin n_bad++;
         $display("FAIL mid_after_wr: diff idx %0d err=%b want -1/0", d, g_err); end
      commit_write(8'h20, 1);
      run_txn(1, SLV, 8'h20, 1, 0, 0, g_err, g_step);
      d = rd_diff(8'h20, 1);
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL mid_after_rd: diff idx %0d want -1", d); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_backpressure();
      test_max_len();
      test_absent(1'b0);
      test_absent(1'b1);
      test_data_nack();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
